// File: rtl/butterfly_array_pipe_if.sv
// rtl/butterfly_array_pipe_if.sv - Beat, twiddle-ROM and result signals of butterfly_array_pipe
interface butterfly_array_pipe_if #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 128,
  parameter int LUT_SIZE = 1360
);
  localparam int AW = $clog2(LUT_SIZE);

  logic                  i_start;
  logic [AW-1:0]         i_w_base;
  logic [AW-1:0]         i_w_stride;
  logic                  i_in_valid;
  logic [1:0]            i_mode;
  logic                  i_swap;
  logic [SIZE*WIDTH-1:0] i_a;
  logic [SIZE*WIDTH-1:0] i_b;
  logic [WIDTH-1:0]      i_modulus;
  logic [SIZE*WIDTH-1:0] i_w;
  logic [AW-1:0]         o_w_idx;
  logic                  o_out_valid;
  logic [SIZE*WIDTH-1:0] o_a_out;
  logic [SIZE*WIDTH-1:0] o_b_out;
  logic                  o_idle;

  modport master (
    output i_start, i_w_base, i_w_stride, i_in_valid, i_mode, i_swap,
           i_a, i_b, i_modulus, i_w,
    input  o_w_idx, o_out_valid, o_a_out, o_b_out, o_idle
  );

  modport slave (
    input  i_start, i_w_base, i_w_stride, i_in_valid, i_mode, i_swap,
           i_a, i_b, i_modulus, i_w,
    output o_w_idx, o_out_valid, o_a_out, o_b_out, o_idle
  );
endinterface

// File: rtl/butterfly_array_pipe.sv
// rtl/butterfly_array_pipe.sv - SIZE-lane pipelined modular butterfly/multiply array with twiddle address generator
module butterfly_array_pipe #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 128,
  parameter int LUT_SIZE = 1360,
  parameter int ROM_LAT  = 1,
  parameter int MUL_LAT  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  butterfly_array_pipe_if.slave bus
);
  localparam int AW = $clog2(LUT_SIZE);

  typedef enum logic [1:0] {
    MODE_DIT = 2'b00,
    MODE_DIF = 2'b01,
    MODE_MUL = 2'b10,
    MODE_BYP = 2'b11
  } mode_e;

  typedef logic [SIZE-1:0][WIDTH-1:0] lanes_t;

  typedef struct packed {
    mode_e            mode;
    logic             swap;
    logic [WIDTH-1:0] q;
    lanes_t           a;
    lanes_t           b;
  } beat_t;

  function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] x, y, q);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= {1'b0, q}) ? WIDTH'(s - {1'b0, q}) : s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x, y, q);
    return (x < y) ? (x + q - y) : (x - y);
  endfunction

  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_idx;
  logic [AW:0]   w_cnt_sum;
  logic [AW-1:0] w_cnt_next;

  assign w_idx      = bus.i_start ? bus.i_w_base : r_cnt;
  assign w_cnt_sum  = {1'b0, w_idx} + {1'b0, bus.i_w_stride};
  assign w_cnt_next = (w_cnt_sum >= (AW+1)'(LUT_SIZE)) ? AW'(w_cnt_sum - (AW+1)'(LUT_SIZE))
                                                       : w_cnt_sum[AW-1:0];
  assign bus.o_w_idx = w_idx;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (bus.i_in_valid) begin
      r_cnt <= w_cnt_next;
    end else if (bus.i_start) begin
      r_cnt <= bus.i_w_base;
    end
  end

  beat_t                             w_in_beat;
  beat_t                             r_dly [ROM_LAT];
  logic  [ROM_LAT-1:0]               r_dly_v;
  beat_t                             w_dsrc;
  beat_t                             w_pre_beat;
  lanes_t                            w_pre_x;
  beat_t                             r_pre;
  lanes_t                            r_pre_x;
  lanes_t                            r_pre_w;
  logic                              r_pre_v;
  logic  [SIZE-1:0][2*WIDTH-1:0]     r_prod;
  lanes_t                            r_mt [MUL_LAT-1];
  beat_t                             r_ms [MUL_LAT];
  logic  [MUL_LAT-1:0]               r_mv;
  beat_t                             w_post;
  lanes_t                            w_t;
  lanes_t                            w_out_a;
  lanes_t                            w_out_b;
  lanes_t                            r_a_out;
  lanes_t                            r_b_out;
  logic                              r_out_v;

  always_comb begin
    w_in_beat      = '0;
    w_in_beat.mode = mode_e'(bus.i_mode);
    w_in_beat.swap = bus.i_swap;
    w_in_beat.q    = bus.i_modulus;
    w_in_beat.a    = bus.i_a;
    w_in_beat.b    = bus.i_b;
  end

  // Operands wait ROM_LAT cycles so they meet the twiddle word fetched for w_idx.
  always_ff @(posedge i_clk) begin
    r_dly[0] <= w_in_beat;
    for (int k = 1; k < ROM_LAT; k++) r_dly[k] <= r_dly[k-1];
  end

  assign w_dsrc = r_dly[ROM_LAT-1];

  // DIF folds A+B into the A slot here; the multiplier operand is picked per mode.
  always_comb begin
    w_pre_beat = w_dsrc;
    w_pre_x    = '0;
    for (int l = 0; l < SIZE; l++) begin
      if (w_dsrc.mode == MODE_DIF) w_pre_beat.a[l] = add_mod(w_dsrc.a[l], w_dsrc.b[l], w_dsrc.q);
      case (w_dsrc.mode)
        MODE_DIF: w_pre_x[l] = sub_mod(w_dsrc.a[l], w_dsrc.b[l], w_dsrc.q);
        MODE_MUL: w_pre_x[l] = w_dsrc.swap ? w_dsrc.a[l] : w_dsrc.b[l];
        default:  w_pre_x[l] = w_dsrc.b[l];
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    r_pre   <= w_pre_beat;
    r_pre_x <= w_pre_x;
    r_pre_w <= bus.i_w;
  end

  // Multiplier needs MUL_LAT >= 2: raw product, exact reduction, then plain delay.
  always_ff @(posedge i_clk) begin
    for (int l = 0; l < SIZE; l++) begin
      r_prod[l]  <= {{WIDTH{1'b0}}, r_pre_x[l]} * {{WIDTH{1'b0}}, r_pre_w[l]};
      r_mt[0][l] <= WIDTH'(r_prod[l] % {{WIDTH{1'b0}}, r_ms[0].q});
    end
    for (int k = 1; k < MUL_LAT - 1; k++) r_mt[k] <= r_mt[k-1];
    r_ms[0] <= r_pre;
    for (int k = 1; k < MUL_LAT; k++) r_ms[k] <= r_ms[k-1];
  end

  assign w_post = r_ms[MUL_LAT-1];
  assign w_t    = r_mt[MUL_LAT-2];

  always_comb begin
    w_out_a = '0;
    w_out_b = '0;
    for (int l = 0; l < SIZE; l++) begin
      case (w_post.mode)
        MODE_DIT: begin
          w_out_a[l] = add_mod(w_post.a[l], w_t[l], w_post.q);
          w_out_b[l] = sub_mod(w_post.a[l], w_t[l], w_post.q);
        end
        MODE_DIF: begin
          w_out_a[l] = w_post.a[l];
          w_out_b[l] = w_t[l];
        end
        MODE_MUL: begin
          w_out_a[l] = w_post.swap ? w_t[l] : w_post.a[l];
          w_out_b[l] = w_post.swap ? w_post.b[l] : w_t[l];
        end
        default: begin
          w_out_a[l] = w_post.a[l];
          w_out_b[l] = w_post.b[l];
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dly_v <= '0;
      r_pre_v <= 1'b0;
      r_mv    <= '0;
      r_out_v <= 1'b0;
      r_a_out <= '0;
      r_b_out <= '0;
    end else begin
      r_dly_v[0] <= bus.i_in_valid;
      for (int k = 1; k < ROM_LAT; k++) r_dly_v[k] <= r_dly_v[k-1];
      r_pre_v <= r_dly_v[ROM_LAT-1];
      r_mv[0] <= r_pre_v;
      for (int k = 1; k < MUL_LAT; k++) r_mv[k] <= r_mv[k-1];
      r_out_v <= r_mv[MUL_LAT-1];
      if (r_mv[MUL_LAT-1]) begin
        r_a_out <= w_out_a;
        r_b_out <= w_out_b;
      end
    end
  end

  assign bus.o_out_valid = r_out_v;
  assign bus.o_a_out     = r_a_out;
  assign bus.o_b_out     = r_b_out;
  assign bus.o_idle      = !bus.i_in_valid && !(|r_dly_v) && !r_pre_v && !(|r_mv);
endmodule

// File: tb/tb_butterfly_array_pipe.sv
// tb/tb_butterfly_array_pipe.sv - Directed-vector bench for butterfly_array_pipe (SIZE=4, WIDTH=8)
module tb_butterfly_array_pipe;
  localparam int WIDTH    = 8;
  localparam int SIZE     = 4;
  localparam int LUT_SIZE = 1360;
  localparam int ROM_LAT  = 1;
  localparam int MUL_LAT  = 2;
  localparam int AW       = $clog2(LUT_SIZE);
  localparam int DW       = SIZE * WIDTH;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [DW-1:0] pend_w;

  butterfly_array_pipe_if #(.WIDTH(WIDTH), .SIZE(SIZE), .LUT_SIZE(LUT_SIZE)) bus ();

  butterfly_array_pipe #(
    .WIDTH(WIDTH), .SIZE(SIZE), .LUT_SIZE(LUT_SIZE), .ROM_LAT(ROM_LAT), .MUL_LAT(MUL_LAT)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rep(input logic [WIDTH-1:0] v);
    return {SIZE{v}};
  endfunction

  // One slot per clock: ROM data for the previous slot's w_idx appears here.
  task automatic nxt();
    @(negedge clk);
    bus.i_w        = pend_w;
    bus.i_in_valid = 1'b0;
    bus.i_start    = 1'b0;
  endtask

  task automatic send(input logic [1:0] m, input logic s, input logic [DW-1:0] a, b, w,
                      input logic [WIDTH-1:0] q);
    bus.i_in_valid = 1'b1;
    bus.i_mode     = m;
    bus.i_swap     = s;
    bus.i_a        = a;
    bus.i_b        = b;
    bus.i_modulus  = q;
    pend_w         = w;
  endtask

  task automatic test_reset();
    nxt(); rst = 1'b1; send(2'd0, 1'b0, rep(8'd3), rep(8'd5), rep(8'd4), 8'd17);
    nxt(); send(2'd0, 1'b0, rep(8'd3), rep(8'd5), rep(8'd4), 8'd17);
    nxt(); rst = 1'b0; #1;
    n_checks++; if (bus.o_out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %0b expected 0", bus.o_out_valid); end
    n_checks++; if (bus.o_a_out !== '0) begin n_errors++; $display("FAIL reset_a_out: got %0h expected 0", bus.o_a_out); end
    n_checks++; if (bus.o_b_out !== '0) begin n_errors++; $display("FAIL reset_b_out: got %0h expected 0", bus.o_b_out); end
    n_checks++; if (bus.o_idle !== 1'b1) begin n_errors++; $display("FAIL reset_idle: got %0b expected 1", bus.o_idle); end
    n_checks++; if (bus.o_w_idx !== 11'd0) begin n_errors++; $display("FAIL reset_w_idx: got %0d expected 0", bus.o_w_idx); end
    for (int c = 0; c < 6; c++) begin
      nxt(); #1;
      n_checks++; if (bus.o_out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_beat_ignored: slot %0d out_valid %0b expected 0", c, bus.o_out_valid); end
    end
  endtask

  task automatic test_modes();
    int t_mode [7] = '{0, 1, 2, 2, 3, 0, 1};
    int t_swap [7] = '{0, 0, 0, 1, 0, 0, 0};
    int t_a    [7] = '{3, 3, 3, 3, 3, 16, 0};
    int t_b    [7] = '{5, 5, 5, 5, 5, 16, 1};
    int t_w    [7] = '{4, 4, 4, 4, 4, 16, 1};
    int t_ea   [7] = '{6, 8, 3, 12, 3, 0, 1};
    int t_eb   [7] = '{0, 9, 3, 5, 5, 15, 16};
    for (int i = 0; i < 7; i++) begin
      nxt(); #1;
      if (i > 0) begin
        n_checks++; if (bus.o_a_out !== rep(WIDTH'(t_ea[i-1]))) begin n_errors++; $display("FAIL mode_hold_a case %0d: got %0h expected %0h", i-1, bus.o_a_out, rep(WIDTH'(t_ea[i-1]))); end
      end
      send(2'(t_mode[i]), t_swap[i][0], rep(WIDTH'(t_a[i])), rep(WIDTH'(t_b[i])), rep(WIDTH'(t_w[i])), 8'd17);
      for (int c = 1; c < 5; c++) begin
        nxt(); #1;
        n_checks++; if (bus.o_out_valid !== 1'b0) begin n_errors++; $display("FAIL mode_early_valid case %0d slot %0d: got %0b expected 0", i, c, bus.o_out_valid); end
        n_checks++; if (bus.o_idle !== 1'b0) begin n_errors++; $display("FAIL mode_idle_busy case %0d slot %0d: got %0b expected 0", i, c, bus.o_idle); end
      end
      nxt(); #1;
      n_checks++; if (bus.o_out_valid !== 1'b1) begin n_errors++; $display("FAIL mode_valid case %0d: got %0b expected 1", i, bus.o_out_valid); end
      n_checks++; if (bus.o_a_out !== rep(WIDTH'(t_ea[i]))) begin n_errors++; $display("FAIL mode_a_out case %0d: got %0h expected %0h", i, bus.o_a_out, rep(WIDTH'(t_ea[i]))); end
      n_checks++; if (bus.o_b_out !== rep(WIDTH'(t_eb[i]))) begin n_errors++; $display("FAIL mode_b_out case %0d: got %0h expected %0h", i, bus.o_b_out, rep(WIDTH'(t_eb[i]))); end
    end
  endtask

  task automatic test_addr_wrap();
    int seq_start  [10] = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 0};
    int seq_base   [10] = '{1358, 0, 0, 100, 0, 50, 0, 0, 1357, 0};
    int seq_stride [10] = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
    int seq_valid  [10] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1};
    int seq_exp    [10] = '{1358, 1, 4, 100, 103, 50, 50, 50, 1357, 0};
    for (int i = 0; i < 10; i++) begin
      nxt();
      bus.i_start    = seq_start[i][0];
      bus.i_w_base   = AW'(seq_base[i]);
      bus.i_w_stride = AW'(seq_stride[i]);
      if (seq_valid[i] != 0) send(2'd3, 1'b0, rep(8'd1), rep(8'd2), rep(8'd0), 8'd17);
      #1;
      n_checks++; if (bus.o_w_idx !== AW'(seq_exp[i])) begin n_errors++; $display("FAIL addr_w_idx step %0d: got %0d expected %0d", i, bus.o_w_idx, seq_exp[i]); end
    end
    repeat (6) nxt();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] ea [10];
    logic [DW-1:0] eb [10];
    logic [DW-1:0] va, vb, vw;
    int q, m, s, av, bv, wv, t, ao, bo;
    q = 113;
    for (int slot = 0; slot < 16; slot++) begin
      nxt();
      if (slot < 10) begin
        m = slot % 4;
        s = (slot / 4) % 2;
        for (int l = 0; l < SIZE; l++) begin
          av = int'($urandom_range(q - 1));
          bv = int'($urandom_range(q - 1));
          wv = int'($urandom_range(q - 1));
          case (m)
            0: begin t = (bv * wv) % q; ao = (av + t) % q; bo = (av - t + q) % q; end
            1: begin ao = (av + bv) % q; bo = (((av - bv + q) % q) * wv) % q; end
            2: begin
              if (s != 0) begin ao = (av * wv) % q; bo = bv; end
              else begin ao = av; bo = (bv * wv) % q; end
            end
            default: begin ao = av; bo = bv; end
          endcase
          va[l*WIDTH +: WIDTH] = WIDTH'(av);
          vb[l*WIDTH +: WIDTH] = WIDTH'(bv);
          vw[l*WIDTH +: WIDTH] = WIDTH'(wv);
          ea[slot][l*WIDTH +: WIDTH] = WIDTH'(ao);
          eb[slot][l*WIDTH +: WIDTH] = WIDTH'(bo);
        end
        send(2'(m), s[0], va, vb, vw, WIDTH'(q));
      end
      #1;
      if (slot >= 5 && slot < 15) begin
        n_checks++; if (bus.o_out_valid !== 1'b1) begin n_errors++; $display("FAIL stream_valid slot %0d: got %0b expected 1", slot, bus.o_out_valid); end
        n_checks++; if (bus.o_a_out !== ea[slot-5]) begin n_errors++; $display("FAIL stream_a_out beat %0d: got %0h expected %0h", slot-5, bus.o_a_out, ea[slot-5]); end
        n_checks++; if (bus.o_b_out !== eb[slot-5]) begin n_errors++; $display("FAIL stream_b_out beat %0d: got %0h expected %0h", slot-5, bus.o_b_out, eb[slot-5]); end
      end else begin
        n_checks++; if (bus.o_out_valid !== 1'b0) begin n_errors++; $display("FAIL stream_quiet slot %0d: got %0b expected 0", slot, bus.o_out_valid); end
      end
      n_checks++; if (bus.o_idle !== (slot >= 14)) begin n_errors++; $display("FAIL stream_idle slot %0d: got %0b expected %0b", slot, bus.o_idle, slot >= 14); end
    end
  endtask

  task automatic test_reset_mid();
    nxt();
    bus.i_start = 1'b1; bus.i_w_base = 11'd7; bus.i_w_stride = 11'd5;
    send(2'd0, 1'b0, rep(8'd3), rep(8'd5), rep(8'd4), 8'd17);
    nxt(); send(2'd1, 1'b0, rep(8'd3), rep(8'd5), rep(8'd4), 8'd17);
    nxt(); rst = 1'b1; send(2'd2, 1'b0, rep(8'd3), rep(8'd5), rep(8'd4), 8'd17);
    nxt(); rst = 1'b0; #1;
    n_checks++; if (bus.o_idle !== 1'b1) begin n_errors++; $display("FAIL midreset_idle: got %0b expected 1", bus.o_idle); end
    n_checks++; if (bus.o_w_idx !== 11'd0) begin n_errors++; $display("FAIL midreset_w_idx: got %0d expected 0", bus.o_w_idx); end
    for (int c = 0; c < 9; c++) begin
      n_checks++; if (bus.o_out_valid !== 1'b0) begin n_errors++; $display("FAIL midreset_discard slot %0d: got %0b expected 0", c, bus.o_out_valid); end
      nxt(); #1;
    end
    send(2'd1, 1'b0, rep(8'd3), rep(8'd5), rep(8'd4), 8'd17);
    for (int c = 1; c < 5; c++) begin
      nxt(); #1;
      n_checks++; if (bus.o_out_valid !== 1'b0) begin n_errors++; $display("FAIL midreset_new_early slot %0d: got %0b expected 0", c, bus.o_out_valid); end
    end
    nxt(); #1;
    n_checks++; if (bus.o_out_valid !== 1'b1) begin n_errors++; $display("FAIL midreset_new_valid: got %0b expected 1", bus.o_out_valid); end
    n_checks++; if (bus.o_a_out !== rep(8'd8)) begin n_errors++; $display("FAIL midreset_new_a: got %0h expected %0h", bus.o_a_out, rep(8'd8)); end
    n_checks++; if (bus.o_b_out !== rep(8'd9)) begin n_errors++; $display("FAIL midreset_new_b: got %0h expected %0h", bus.o_b_out, rep(8'd9)); end
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst            = 1'b1;
    pend_w         = '0;
    bus.i_start    = 1'b0;
    bus.i_w_base   = '0;
    bus.i_w_stride = '0;
    bus.i_in_valid = 1'b0;
    bus.i_mode     = 2'd0;
    bus.i_swap     = 1'b0;
    bus.i_a        = '0;
    bus.i_b        = '0;
    bus.i_w        = '0;
    bus.i_modulus  = 8'd17;
    test_reset();
    test_modes();
    test_addr_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/butterfly_array_pipe.md
# butterfly_array_pipe

Pipelined, parametrised successor to the NTT butterfly array: SIZE parallel lanes of modular butterfly or multiply units sharing one twiddle-ROM address stream, with valid tracking and an on-chip twiddle address generator. Sits between the coefficient memory banks and the NTT/INTT controller. Supports DIT butterfly (forward), DIF butterfly (inverse), pointwise multiply and bypass per beat. Fixed latency, no backpressure.

## Interface
- WIDTH, 32: coefficient and modulus width.
- SIZE, 128: lane count.
- LUT_SIZE, 1360: twiddle ROM depth (entries of SIZE*WIDTH bits).
- ROM_LAT, 1: external twiddle ROM read latency, cycles (>=1).
- MUL_LAT, 2: pipeline stages of the modular multiplier.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse: load twiddle address counter from w_base.
- w_base  in  $clog2(LUT_SIZE)  first twiddle address of a pass.
- w_stride  in  $clog2(LUT_SIZE)  address increment per beat; must be < LUT_SIZE.
- in_valid  in  1  beat present on A/B.
- mode  in  2  00 DIT, 01 DIF, 10 MUL, 11 bypass; sampled with the beat.
- swap  in  1  MUL only: multiply A instead of B.
- A, B  in  SIZE*WIDTH each  lane operands, lane i at [i*WIDTH +: WIDTH], each < modulus.
- modulus  in  WIDTH  q; odd, 3 <= q < 2^(WIDTH-1); sampled with the beat.
- w_idx  out  $clog2(LUT_SIZE)  twiddle ROM address for the current beat.
- W  in  SIZE*WIDTH  twiddle ROM data, ROM_LAT cycles after w_idx; lane i at [i*WIDTH +: WIDTH].
- out_valid  out  1  A_out/B_out hold a result.
- A_out, B_out  out  SIZE*WIDTH each  results, in [0, q).
- idle  out  1  no beat in flight.

## Operation
- Per lane, all arithmetic mod q, every result fully reduced to [0,q):
  - DIT: t = B*W; A_out = A+t; B_out = A−t.
  - DIF: A_out = A+B; B_out = (A−B)*W.
  - MUL: swap=0: A_out = A, B_out = B*W; swap=1: A_out = A*W, B_out = B.
  - Bypass: A_out = A, B_out = B; W ignored.
- Add: sum − q if sum >= q. Sub: diff + q if A < B. Multiply: full 2*WIDTH product reduced exactly mod q (reduction method free, must fit MUL_LAT stages).
- mode, swap, modulus, A, B travel with the beat; changing them mid-stream affects only later beats.
- Address generator: register cnt. w_idx = start ? w_base : cnt (combinational). On cycle with in_valid: cnt <= w_idx + w_stride, minus LUT_SIZE if >= LUT_SIZE. On start without in_valid: cnt <= w_base. Otherwise cnt holds.
- Operands are delayed ROM_LAT cycles internally to align with W; no external alignment required.
- No backpressure: every accepted beat emerges exactly LATENCY cycles later; consumer must always accept.

## Timing
- LATENCY = ROM_LAT + MUL_LAT + 2 for every mode (bypass and MUL padded to match). Default 5.
- in_valid at cycle t -> out_valid at t+LATENCY with that beat's results; order preserved; back-to-back beats at 1/cycle.
- w_idx valid in the same cycle as in_valid; W sampled at t+ROM_LAT.
- idle = 1 iff no valid bit set anywhere in the pipeline and in_valid = 0.
- Reset (synchronous): all valid bits 0, A_out/B_out 0, out_valid 0, cnt 0, idle 1. Reset mid-operation discards all in-flight beats: none of them ever raises out_valid. in_valid during reset ignored.
- start and in_valid same cycle: beat uses w_base; next beat uses w_base + w_stride.
- A_out/B_out hold last result when out_valid = 0 (not required to be zeroed).

## Test plan
- DIT, SIZE=4, WIDTH=8, q=17, A=3, B=5, W=4 all lanes -> after 5 cycles out_valid=1, A_out=6, B_out=0 every lane.
- DIF same operands -> A_out=8, B_out=9; MUL swap=0 -> A_out=3, B_out=3; MUL swap=1 -> A_out=12, B_out=5; bypass -> 3, 5.
- Boundary values q=17: A=16, B=16, W=16, DIT -> t=1, A_out=0, B_out=15; A=0, B=1, DIF, W=1 -> A_out=1, B_out=16.
- Address wrap: LUT_SIZE=1360, start with w_base=1358, w_stride=3, three beats -> w_idx 1358, 1, 4; a concurrent second start mid-stream reloads w_base on that beat.
- Streaming: 10 consecutive beats with alternating modes and random lanes vs. golden model -> 10 consecutive out_valid cycles, in order, bit-exact, idle low throughout and high 5 cycles after last beat.
- Reset mid-op: issue 3 beats, assert reset one cycle at cycle 2 -> out_valid never asserts for them, idle=1 and w_idx=0 the cycle after reset; a new beat afterwards emerges exactly 5 cycles later.
